// File: rtl/regfile_scoreboard.sv
// Integer register file with a write-back bypass and a per-register busy scoreboard.
// Decode uses the busy outputs to stall on RAW and WAW hazards.
module regfile_scoreboard #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = $clog2(NREGS),
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    rs1_addr,
    input  logic [AW-1:0]    rs2_addr,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    output logic             rs1_busy,
    output logic             rs2_busy,
    input  logic             issue_en,
    input  logic [AW-1:0]    issue_rd,
    output logic             issue_ok,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_addr,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             flush,
    output logic [NREGS-1:0] busy_vec,
    output logic [AW:0]      pending_cnt
);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [AW:0]      r_cnt;

    logic             w_hit1, w_hit2, w_zero1, w_zero2;
    logic             w_rd_zero, w_rd_retire, w_set, w_inc, w_dec;
    logic [NREGS-1:0] w_busy_nxt;
    logic [AW:0]      w_cnt_nxt;

    // Read ports: hardwired zero first, then same-cycle write-back forwarding.
    always_comb begin
        w_zero1 = ZERO_REG && (rs1_addr == '0);
        w_zero2 = ZERO_REG && (rs2_addr == '0);
        w_hit1  = BYPASS && wb_en && (wb_addr == rs1_addr);
        w_hit2  = BYPASS && wb_en && (wb_addr == rs2_addr);

        if (w_zero1)     rs1_data = '0;
        else if (w_hit1) rs1_data = wb_data;
        else             rs1_data = r_regs[rs1_addr];

        if (w_zero2)     rs2_data = '0;
        else if (w_hit2) rs2_data = wb_data;
        else             rs2_data = r_regs[rs2_addr];

        rs1_busy = r_busy[rs1_addr] && !w_hit1 && !w_zero1;
        rs2_busy = r_busy[rs2_addr] && !w_hit2 && !w_zero2;
    end

    // A busy destination may be reclaimed only when it retires in the same cycle.
    always_comb begin
        w_rd_zero   = ZERO_REG && (issue_rd == '0);
        w_rd_retire = wb_en && (wb_addr == issue_rd);
        issue_ok    = issue_en && !flush &&
                      (w_rd_zero || !r_busy[issue_rd] || w_rd_retire);
        w_set       = issue_ok && !w_rd_zero;
        w_inc       = w_set && !r_busy[issue_rd];
        w_dec       = wb_en && r_busy[wb_addr] && !(w_set && (issue_rd == wb_addr));

        w_busy_nxt = r_busy;
        w_cnt_nxt  = r_cnt;
        if (flush) begin
            w_busy_nxt = '0;
            w_cnt_nxt  = '0;
        end else begin
            if (wb_en) w_busy_nxt[wb_addr] = 1'b0;
            if (w_set) w_busy_nxt[issue_rd] = 1'b1;
            w_cnt_nxt = r_cnt + {{AW{1'b0}}, w_inc} - {{AW{1'b0}}, w_dec};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            if (wb_en && !(ZERO_REG && (wb_addr == '0))) r_regs[wb_addr] <= wb_data;
            r_busy <= w_busy_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign busy_vec    = r_busy;
    assign pending_cnt = r_cnt;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed vector table, BYPASS=0 sequence, and
// randomized traffic against an array-based reference model.
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1_addr, rs2_addr, issue_rd, wb_addr;
    logic        issue_en, wb_en, flush;
    logic [31:0] wb_data;

    logic [31:0] b1_d1, b1_d2, b0_d1, b0_d2;
    logic        b1_bz1, b1_bz2, b0_bz1, b0_bz2, b1_ok, b0_ok;
    logic [31:0] b1_bv, b0_bv;
    logic [5:0]  b1_pc, b0_pc;

    regfile_scoreboard #(.XLEN(32), .NREGS(32), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_byp (
        .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(b1_d1), .rs2_data(b1_d2), .rs1_busy(b1_bz1), .rs2_busy(b1_bz2),
        .issue_en(issue_en), .issue_rd(issue_rd), .issue_ok(b1_ok),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
        .busy_vec(b1_bv), .pending_cnt(b1_pc)
    );

    regfile_scoreboard #(.XLEN(32), .NREGS(32), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_nobyp (
        .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(b0_d1), .rs2_data(b0_d2), .rs1_busy(b0_bz1), .rs2_busy(b0_bz2),
        .issue_en(issue_en), .issue_rd(issue_rd), .issue_ok(b0_ok),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
        .busy_vec(b0_bv), .pending_cnt(b0_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: architectural register values and the set of claimed destinations.
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    bit          model_on = 1'b0;

    function automatic logic [31:0] m_read(input logic [4:0] a, input bit byp);
        if (a == 0) return 32'h0;
        if (byp && wb_en && wb_addr == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic logic m_rbusy(input logic [4:0] a, input bit byp);
        return (a != 0) && m_busy[a] && !(byp && wb_en && wb_addr == a);
    endfunction

    function automatic logic m_ok();
        return issue_en && !flush &&
               (issue_rd == 0 || !m_busy[issue_rd] || (wb_en && wb_addr == issue_rd));
    endfunction

    function automatic logic [31:0] m_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic logic [31:0] m_cnt();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
        return 32'(n);
    endfunction

    // Called after the falling edge: compare both builds, advance the model, cross the rising edge.
    task automatic step();
        logic ok;
        if (model_on) begin
            chk("b1.rs1_data", b1_d1, m_read(rs1_addr, 1'b1));
            chk("b1.rs2_data", b1_d2, m_read(rs2_addr, 1'b1));
            chk("b1.rs1_busy", 32'(b1_bz1), 32'(m_rbusy(rs1_addr, 1'b1)));
            chk("b1.rs2_busy", 32'(b1_bz2), 32'(m_rbusy(rs2_addr, 1'b1)));
            chk("b1.issue_ok", 32'(b1_ok), 32'(m_ok()));
            chk("b1.busy_vec", b1_bv, m_vec());
            chk("b1.pending",  32'(b1_pc), m_cnt());
            chk("b0.rs1_data", b0_d1, m_read(rs1_addr, 1'b0));
            chk("b0.rs2_data", b0_d2, m_read(rs2_addr, 1'b0));
            chk("b0.rs1_busy", 32'(b0_bz1), 32'(m_rbusy(rs1_addr, 1'b0)));
            chk("b0.rs2_busy", 32'(b0_bz2), 32'(m_rbusy(rs2_addr, 1'b0)));
            chk("b0.issue_ok", 32'(b0_ok), 32'(m_ok()));
            chk("b0.busy_vec", b0_bv, m_vec());
            chk("b0.pending",  32'(b0_pc), m_cnt());
        end
        ok = m_ok();
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
            if (flush) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            end else begin
                if (wb_en) m_busy[wb_addr] = 1'b0;
                if (ok && issue_rd != 0) m_busy[issue_rd] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                         input logic ie, input logic [4:0] rd, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd, input logic fl);
        rst = r; rs1_addr = a1; rs2_addr = a2; issue_en = ie; issue_rd = rd;
        wb_en = we; wb_addr = wa; wb_data = wd; flush = fl;
    endtask

    typedef struct {
        logic        rst;
        logic [4:0]  a1, a2;
        logic        ie;
        logic [4:0]  rd;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        fl;
        logic [31:0] e_d1;
        logic        e_b1;
        logic [31:0] e_d2;
        logic        e_b2;
        logic        e_ok;
        logic [31:0] e_bv;
        logic [5:0]  e_pc;
    } vec_t;

    vec_t tbl [13];

    initial begin
        // Expectations for the BYPASS=1 build; state columns are the values before the edge.
        tbl[0]  = '{1'b0, 5'd5, 5'd0, 1'b1, 5'd5, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0,  1'b0, 1'b1, 32'h00, 6'd0};
        tbl[1]  = '{1'b1, 5'd5, 5'd0, 1'b1, 5'd6, 1'b1, 5'd6, 32'h99,       1'b0, 32'hDEADBEEF, 1'b1, 32'h0,  1'b0, 1'b1, 32'h20, 6'd1};
        tbl[2]  = '{1'b0, 5'd5, 5'd6, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,  1'b0, 1'b1, 32'h00, 6'd0};
        tbl[3]  = '{1'b0, 5'd7, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 32'h1234,     1'b0, 32'h1234,     1'b0, 32'h0,  1'b0, 1'b0, 32'h80, 6'd1};
        tbl[4]  = '{1'b0, 5'd7, 5'd0, 1'b1, 5'd3, 1'b0, 5'd0, 32'h0,        1'b0, 32'h1234,     1'b0, 32'h0,  1'b0, 1'b1, 32'h00, 6'd0};
        tbl[5]  = '{1'b0, 5'd3, 5'd0, 1'b1, 5'd3, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0,  1'b0, 1'b0, 32'h08, 6'd1};
        tbl[6]  = '{1'b0, 5'd3, 5'd0, 1'b1, 5'd3, 1'b1, 5'd3, 32'h33,       1'b0, 32'h33,       1'b0, 32'h0,  1'b0, 1'b1, 32'h08, 6'd1};
        tbl[7]  = '{1'b0, 5'd3, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 32'h33,       1'b1, 32'h0,  1'b0, 1'b1, 32'h08, 6'd1};
        tbl[8]  = '{1'b0, 5'd0, 5'd0, 1'b1, 5'd1, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,  1'b0, 1'b1, 32'h08, 6'd1};
        tbl[9]  = '{1'b0, 5'd1, 5'd0, 1'b1, 5'd2, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0,  1'b0, 1'b1, 32'h0A, 6'd2};
        tbl[10] = '{1'b0, 5'd4, 5'd3, 1'b1, 5'd4, 1'b1, 5'd3, 32'h44,       1'b0, 32'h0,        1'b0, 32'h44, 1'b0, 1'b1, 32'h0E, 6'd3};
        tbl[11] = '{1'b0, 5'd2, 5'd9, 1'b1, 5'd9, 1'b1, 5'd2, 32'h55,       1'b1, 32'h55,       1'b0, 32'h0,  1'b0, 1'b0, 32'h16, 6'd3};
        tbl[12] = '{1'b0, 5'd2, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        1'b0, 32'h55,       1'b0, 32'h44, 1'b0, 1'b0, 32'h00, 6'd0};

        drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0);
        @(posedge clk); #1;
        @(negedge clk); step();
        @(negedge clk); step();
        model_on = 1'b1;

        // Reset state
        drive(1'b0, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0);
        @(negedge clk);
        chk("reset.rs1_data", b1_d1, 32'h0);
        chk("reset.busy_vec", b1_bv, 32'h0);
        chk("reset.pending",  32'(b1_pc), 32'h0);
        step();

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].rst, tbl[i].a1, tbl[i].a2, tbl[i].ie, tbl[i].rd,
                  tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].fl);
            @(negedge clk);
            chk($sformatf("vec%0d.rs1_data", i), b1_d1, tbl[i].e_d1);
            chk($sformatf("vec%0d.rs1_busy", i), 32'(b1_bz1), 32'(tbl[i].e_b1));
            chk($sformatf("vec%0d.rs2_data", i), b1_d2, tbl[i].e_d2);
            chk($sformatf("vec%0d.rs2_busy", i), 32'(b1_bz2), 32'(tbl[i].e_b2));
            chk($sformatf("vec%0d.issue_ok", i), 32'(b1_ok), 32'(tbl[i].e_ok));
            chk($sformatf("vec%0d.busy_vec", i), b1_bv, tbl[i].e_bv);
            chk($sformatf("vec%0d.pending", i),  32'(b1_pc), 32'(tbl[i].e_pc));
            step();
        end

        // BYPASS=0: retiring write is invisible until the following cycle
        drive(1'b0, 5'd6, 5'd0, 1'b1, 5'd6, 1'b0, 5'd0, 32'h0, 1'b0);
        @(negedge clk);
        chk("nobyp.claim_ok", 32'(b0_ok), 32'h1);
        step();
        drive(1'b0, 5'd6, 5'd0, 1'b0, 5'd0, 1'b1, 5'd6, 32'hA5, 1'b0);
        @(negedge clk);
        chk("nobyp.same_data", b0_d1, 32'h0);
        chk("nobyp.same_busy", 32'(b0_bz1), 32'h1);
        chk("byp.same_data",   b1_d1, 32'hA5);
        step();
        drive(1'b0, 5'd6, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0);
        @(negedge clk);
        chk("nobyp.next_data", b0_d1, 32'hA5);
        chk("nobyp.next_busy", 32'(b0_bz1), 32'h0);
        step();

        // Randomized traffic, addresses concentrated on a few registers to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            drive(1'b0,
                  ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7)),
                  1'($urandom), 5'($urandom_range(0, 7)),
                  1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 29) == 0));
            if ($urandom_range(0, 199) == 0) rst = 1'b1;
            @(negedge clk);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
